// File: rtl/seq_pkg.sv
// Shared constants and helpers for the serial pattern detector.
package seq_pkg;

  localparam int DEF_PAT_LEN = 4;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

  // Bits needed to hold values 0..value-1; evaluated at elaboration only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rise_tick.sv
// Two-flop edge detector: one-cycle strobe per rising edge of a level input.
module rise_tick (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_tick
);

  logic r_s0;
  logic r_s1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_sig;
      r_s1 <= r_s0;
    end
  end

  assign o_tick = r_s0 & ~r_s1;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector sampled on slow-clock rising edges, with a match
// pulse, a stretched LED and a saturating match counter.
module seq_detect
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  parameter int                 HOLD    = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             slow_clk,
  input  logic             din,
  output logic             detect,
  output logic             led,
  output logic [CNT_W-1:0] match_count,
  output logic             tick,
  output logic [PAT_LEN-1:0] o_dbg_hist,
  output logic [4:0]       o_dbg_fill
);

  localparam int FILL_W = clog2(PAT_LEN + 1);
  localparam int HOLD_W = clog2(HOLD + 1);

  logic               w_tick;
  logic [PAT_LEN-1:0] w_next_hist;
  logic               w_match;

  // Detector state is (r_fill, r_hist); r_fill masks stale history bits.
  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_detect;
  logic [CNT_W-1:0]   r_count;

  rise_tick u_rise_tick (
    .i_clk  (clk_in),
    .i_rst  (reset),
    .i_sig  (slow_clk),
    .o_tick (w_tick)
  );

  assign w_next_hist = {r_hist[PAT_LEN-2:0], din};
  assign w_match     = w_tick && (r_fill >= FILL_W'(PAT_LEN - 1)) &&
                       (w_next_hist == PATTERN);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_hist   <= '0;
      r_fill   <= '0;
      r_hold   <= '0;
      r_detect <= 1'b0;
      r_count  <= '0;
    end else begin
      r_detect <= w_match;
      if (w_tick) begin
        r_hist <= w_next_hist;
        if (w_match && !OVERLAP) begin
          r_fill <= '0;
        end else if (r_fill != FILL_W'(PAT_LEN)) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
      if (w_match && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end
      // A match always wins over the decrement: reload, never add.
      if (w_match) begin
        r_hold <= HOLD_W'(HOLD);
      end else if (w_tick && (r_hold != '0)) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
    end
  end

  assign detect      = r_detect;
  assign led         = (r_hold != '0);
  assign match_count = r_count;
  assign tick        = w_tick;
  assign o_dbg_hist  = r_hist;
  assign o_dbg_fill  = 5'(r_fill);

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: default, non-overlapping and 2-bit-counter
// instances share one stimulus stream; expectations are hand-derived.
module tb_seq_detect;

  logic       clk_in = 1'b0;
  logic       reset = 1'b0;
  logic       slow_clk = 1'b0;
  logic       din = 1'b0;

  logic       detect_a, led_a, tick_a;
  logic [7:0] count_a;
  logic [3:0] hist_a;
  logic [4:0] fill_a;
  logic       detect_b, led_b, tick_b;
  logic [7:0] count_b;
  logic [3:0] hist_b;
  logic [4:0] fill_b;
  logic       detect_c, led_c, tick_c;
  logic [1:0] count_c;
  logic [3:0] hist_c;
  logic [4:0] fill_c;

  int n_tests = 0;
  int n_fail = 0;
  int pc_a = 0;
  int pc_b = 0;
  int pc_c = 0;
  int ticks_a = 0;
  int t0;

  logic d_early_a, d_late_a, d_late_b, d_late_c;

  seq_detect dut_a (
    .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .din(din),
    .detect(detect_a), .led(led_a), .match_count(count_a), .tick(tick_a),
    .o_dbg_hist(hist_a), .o_dbg_fill(fill_a)
  );

  seq_detect #(.OVERLAP(1'b0)) dut_b (
    .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .din(din),
    .detect(detect_b), .led(led_b), .match_count(count_b), .tick(tick_b),
    .o_dbg_hist(hist_b), .o_dbg_fill(fill_b)
  );

  seq_detect #(.CNT_W(2)) dut_c (
    .clk_in(clk_in), .reset(reset), .slow_clk(slow_clk), .din(din),
    .detect(detect_c), .led(led_c), .match_count(count_c), .tick(tick_c),
    .o_dbg_hist(hist_c), .o_dbg_fill(fill_c)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (detect_a) pc_a++;
    if (detect_b) pc_b++;
    if (detect_c) pc_c++;
    if (tick_a) ticks_a++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    slow_clk = 1'b0;
    din = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
  endtask

  // One slow-clock period: high for 2 fast edges, low for 2.
  task automatic feed_bit(input logic b);
    @(negedge clk_in);
    slow_clk = 1'b1;
    din = b;
    @(negedge clk_in);
    d_early_a = detect_a;
    @(negedge clk_in);
    d_late_a = detect_a;
    d_late_b = detect_b;
    d_late_c = detect_c;
    slow_clk = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic feed_seq(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) feed_bit(bits[n-1-i]);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_det"}, {31'd0, detect_a}, 32'd0);
    check({tag, "_led"}, {31'd0, led_a}, 32'd0);
    check({tag, "_cnt"}, {24'd0, count_a}, 32'd0);
    check({tag, "_tick"}, {31'd0, tick_a}, 32'd0);
    check({tag, "_cnt_b"}, {24'd0, count_b}, 32'd0);
    check({tag, "_cnt_c"}, {30'd0, count_c}, 32'd0);
  endtask

  logic [3:0] led_exp;

  initial begin
    // basic match and LED stretch
    do_reset();
    check_idle("rst");
    feed_seq(32'b101, 3);
    check("basic_pre", {31'd0, d_late_a}, 32'd0);
    feed_bit(1'b1);
    check("basic_latency", {31'd0, d_early_a}, 32'd0);
    check("basic_det", {31'd0, d_late_a}, 32'd1);
    check("basic_det_b", {31'd0, d_late_b}, 32'd1);
    check("basic_det_c", {31'd0, d_late_c}, 32'd1);
    check("basic_cnt", {24'd0, count_a}, 32'd1);
    check("basic_led", {31'd0, led_a}, 32'd1);
    led_exp = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      feed_bit(1'b0);
      check($sformatf("led_hold%0d", i), {31'd0, led_a}, {31'd0, led_exp[3-i]});
    end

    // overlap vs. cleared history
    do_reset();
    feed_seq(32'b1011011, 7);
    check("ovl_cnt_a", {24'd0, count_a}, 32'd2);
    check("novl_cnt_b", {24'd0, count_b}, 32'd1);
    check("ovl_cnt_c", {30'd0, count_c}, 32'd2);
    do_reset();
    feed_seq(32'b10111011, 8);
    check("ovl2_cnt_a", {24'd0, count_a}, 32'd2);
    check("novl2_cnt_b", {24'd0, count_b}, 32'd2);

    // fill guard and no sampling without slow edges
    do_reset();
    feed_seq(32'b011, 3);
    check("guard_cnt", {24'd0, count_a}, 32'd0);
    check("guard_fill", {27'd0, fill_a}, 32'd3);
    feed_seq(32'b101, 3);
    check("guard_hist", {28'd0, hist_a}, 32'hd);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      din = ~din;
    end
    check("hold_hist", {28'd0, hist_a}, 32'hd);
    check("hold_fill", {27'd0, fill_a}, 32'd4);
    feed_bit(1'b1);
    check("guard_det", {31'd0, d_late_a}, 32'd1);

    // reload, tick count, saturation
    do_reset();
    t0 = ticks_a;
    feed_seq(32'b1011, 4);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        feed_bit((i == 0) ? 1'b0 : 1'b1);
        check($sformatf("reload_led_r%0d_%0d", r, i), {31'd0, led_a}, 32'd1);
      end
      if (r == 1) check("sat_cnt_c_3", {30'd0, count_c}, 32'd3);
    end
    feed_bit(1'b0);
    check("tick_count20", ticks_a - t0, 32'd20);
    check("reload_cnt_a", {24'd0, count_a}, 32'd6);
    check("sat_cnt_c", {30'd0, count_c}, 32'd3);
    check("novl_cnt_b6", {24'd0, count_b}, 32'd3);
    led_exp = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      feed_bit(1'b0);
      check($sformatf("reload_tail%0d", i), {31'd0, led_a}, {31'd0, led_exp[3-i]});
    end
    check("sat_cnt_c_end", {30'd0, count_c}, 32'd3);

    // reset mid-pattern
    do_reset();
    feed_seq(32'b101, 3);
    do_reset();
    check_idle("midrst");
    feed_bit(1'b1);
    check("midrst_det", {31'd0, d_late_a}, 32'd0);
    check("midrst_cnt", {24'd0, count_a}, 32'd0);

    // slow_clk already high when reset releases
    @(negedge clk_in);
    reset = 1'b1;
    slow_clk = 1'b1;
    din = 1'b0;
    @(negedge clk_in);
    reset = 1'b0;
    check("rel_tick0", {31'd0, tick_a}, 32'd0);
    @(negedge clk_in);
    check("rel_tick1", {31'd0, tick_a}, 32'd1);
    @(negedge clk_in);
    slow_clk = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);

    check("pulses_a", pc_a, 32'd12);
    check("pulses_b", pc_b, 32'd8);
    check("pulses_c", pc_c, 32'd12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
